kv_req_arbiter: RTL and testbench

Shares the single key-value lookup engine between NUM_REQ packet-parser instances, one per Ethernet port. Each parser raises a key/flag request. The arbiter grants requesters round-robin and issues one-cycle request pulses to the engine. It remembers the issue order and routes each in-order reply back to the requester that caused it. It sits between the per-port parsers and the KV engine, all in the clk156 domain.

---
 rtl/kv_arb_pkg.sv | 15 +
 rtl/kv_tag_fifo.sv | 46 ++++
 rtl/kv_req_arbiter.sv | 102 ++++++++++
 tb/tb_kv_req_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_arb_pkg.sv
// Shared types and constants for the KV request arbiter.
// Status codes are shared with the parsers and engine.
package kv_arb_pkg;

  localparam int FLAG_W_DEF = 4;

  localparam logic [1:0] STATUS_SUSPECT = 2'b01;
  localparam logic [1:0] STATUS_ARREST  = 2'b10;
  localparam logic [1:0] STATUS_FILTERE = 2'b11;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kv_tag_fifo.sv
// In-order tag FIFO recording which requester owns each
// request in flight to the KV engine.
module kv_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk156,
  input  logic             eth_rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk156) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_tag = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/kv_req_arbiter.sv
// Round-robin arbiter sharing one KV lookup engine between
// per-port parsers; routes in-order replies back by tag.
module kv_req_arbiter
  import kv_arb_pkg::*;
#(
  parameter int KEY_SIZE        = 96,
  parameter int FLAG_W          = FLAG_W_DEF,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int TAG_W = tag_width(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                         clk156,
  input  logic                         eth_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*KEY_SIZE-1:0]  req_key,
  input  logic [NUM_REQ*FLAG_W-1:0]    req_flag,
  output logic [KEY_SIZE-1:0]          db_in_key,
  output logic [FLAG_W-1:0]            db_in_flag,
  output logic                         db_in_valid,
  input  logic                         db_out_valid,
  input  logic [FLAG_W-1:0]            db_out_flag,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [FLAG_W-1:0]            rsp_flag,
  output logic [CNT_W-1:0]             outstanding,
  output logic                         orphan
);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] gnt_idx;
  logic [TAG_W-1:0] cand;
  logic [TAG_W:0]   sum;
  logic [TAG_W-1:0] head_tag;
  logic             gnt_found;
  logic             credit;
  logic             grant;
  logic             pop;
  logic             empty;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(NUM_REQ))
        sum = sum - (TAG_W+1)'(NUM_REQ);
      cand = sum[TAG_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Credit uses the registered count only; a same-cycle pop
  // does not free a slot until the next cycle.
  assign credit    = (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign grant     = gnt_found & credit & eth_rst_n;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign pop       = db_out_valid & ~empty;

  kv_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .push      (grant),
    .push_tag  (gnt_idx),
    .pop       (pop),
    .head_tag  (head_tag),
    .empty     (empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rr_ptr      <= '0;
      db_in_valid <= 1'b0;
      db_in_key   <= '0;
      db_in_flag  <= '0;
      rsp_valid   <= '0;
      rsp_flag    <= '0;
      orphan      <= 1'b0;
    end else begin
      db_in_valid <= grant;
      if (grant) begin
        rr_ptr     <= (gnt_idx == TAG_W'(NUM_REQ-1))
                      ? '0 : gnt_idx + 1'b1;
        db_in_key  <= req_key[int'(gnt_idx)*KEY_SIZE +: KEY_SIZE];
        db_in_flag <= req_flag[int'(gnt_idx)*FLAG_W +: FLAG_W];
      end
      rsp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (pop) rsp_flag <= db_out_flag;
      orphan <= db_out_valid & empty;
    end
  end

endmodule

// File: tb/tb_kv_req_arbiter.sv
// Directed self-checking bench for kv_req_arbiter.
// Inputs change 1 time unit after each rising edge.
module tb_kv_req_arbiter;

  localparam int KS = 96;
  localparam int FW = 4;
  localparam int NR = 4;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic              clk156;
  logic              eth_rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*KS-1:0]  req_key;
  logic [NR*FW-1:0]  req_flag;
  logic [KS-1:0]     db_in_key;
  logic [FW-1:0]     db_in_flag;
  logic              db_in_valid;
  logic              db_out_valid;
  logic [FW-1:0]     db_out_flag;
  logic [NR-1:0]     rsp_valid;
  logic [FW-1:0]     rsp_flag;
  logic [CW-1:0]     outstanding;
  logic              orphan;

  int checks = 0;
  int errors = 0;

  kv_req_arbiter #(
    .KEY_SIZE        (KS),
    .FLAG_W          (FW),
    .NUM_REQ         (NR),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk156       (clk156),
    .eth_rst_n    (eth_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_flag     (req_flag),
    .db_in_key    (db_in_key),
    .db_in_flag   (db_in_flag),
    .db_in_valid  (db_in_valid),
    .db_out_valid (db_out_valid),
    .db_out_flag  (db_out_flag),
    .rsp_valid    (rsp_valid),
    .rsp_flag     (rsp_flag),
    .outstanding  (outstanding),
    .orphan       (orphan)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [KS-1:0] k,
                         input logic [FW-1:0] f);
    req_key[i*KS +: KS] = k;
    req_flag[i*FW +: FW] = f;
  endtask

  task automatic do_reset();
    req_valid    = '0;
    db_out_valid = 1'b0;
    eth_rst_n    = 1'b0;
    #1;
    eth_rst_n    = 1'b1;
    tick();
  endtask

  logic [NR-1:0] e;
  int tags [5] = '{1, 3, 0, 2, 1};

  initial begin
    eth_rst_n    = 1'b0;
    req_valid    = '0;
    req_key      = '0;
    req_flag     = '0;
    db_out_valid = 1'b0;
    db_out_flag  = '0;
    tick();
    tick();
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_dbv", db_in_valid, 0);
    chk("rst_key", db_in_key, 0);
    chk("rst_flag", db_in_flag, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rspf", rsp_flag, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_orph", orphan, 0);
    req_valid = '0;
    eth_rst_n = 1'b1;
    tick();

    // single request from requester 2
    set_req(2, 96'hA, 4'b0011);
    req_valid = 4'b0100;
    #1;
    chk("s_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("s_dbv", db_in_valid, 1);
    chk("s_key", db_in_key, 96'hA);
    chk("s_flag", db_in_flag, 3);
    chk("s_out1", outstanding, 1);
    tick();
    chk("s_dbv0", db_in_valid, 0);
    tick();
    db_out_valid = 1'b1;
    db_out_flag  = 4'b0101;
    tick();
    db_out_valid = 1'b0;
    chk("s_rsp", rsp_valid, 4'b0100);
    chk("s_rspf", rsp_flag, 5);
    chk("s_out0", outstanding, 0);
    chk("s_orph", orphan, 0);
    tick();
    chk("s_rsp0", rsp_valid, 0);

    // fairness with immediate in-order replies
    do_reset();
    for (int i = 0; i < NR; i++)
      set_req(i, KS'(32'h100 + i), FW'(i));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      db_out_valid = db_in_valid;
      db_out_flag  = db_in_flag ^ 4'h8;
      #1;
      e = 4'b0001 << (k % 4);
      chk("f_ready", req_ready, e);
      tick();
      chk("f_key", db_in_key, 32'h100 + (k % 4));
      chk("f_out", outstanding, 1);
      if (k > 0) begin
        e = 4'b0001 << ((k - 1) % 4);
        chk("f_rsp", rsp_valid, e);
        chk("f_rspf", rsp_flag, ((k - 1) % 4) ^ 8);
      end
    end
    req_valid    = '0;
    db_out_valid = db_in_valid;
    db_out_flag  = db_in_flag ^ 4'h8;
    tick();
    db_out_valid = 1'b0;
    chk("f_rsp_last", rsp_valid, 4'b1000);
    chk("f_out0", outstanding, 0);

    // credit limit
    do_reset();
    set_req(0, 96'h55, 4'h1);
    req_valid = 4'b0001;
    repeat (8) tick();
    chk("c_out8", outstanding, 8);
    chk("c_ready0", req_ready, 0);
    tick();
    chk("c_dbv0", db_in_valid, 0);
    chk("c_out8b", outstanding, 8);
    db_out_valid = 1'b1;
    db_out_flag  = 4'h2;
    #1;
    chk("c_nobypass", req_ready, 0);
    tick();
    db_out_valid = 1'b0;
    chk("c_out7", outstanding, 7);
    chk("c_rsp", rsp_valid, 4'b0001);
    chk("c_ready1", req_ready, 4'b0001);
    tick();
    chk("c_out8c", outstanding, 8);
    chk("c_dbv1", db_in_valid, 1);
    chk("c_ready0b", req_ready, 0);
    tick();
    chk("c_dbv0b", db_in_valid, 0);
    req_valid = '0;

    // simultaneous grant and reply at outstanding 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001 << tags[i];
      tick();
    end
    chk("m_out5", outstanding, 5);
    req_valid    = 4'b1000;
    db_out_valid = 1'b1;
    db_out_flag  = 4'h6;
    #1;
    chk("m_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("m_out5b", outstanding, 5);
    chk("m_rsp", rsp_valid, 4'b0010);
    chk("m_rspf", rsp_flag, 6);
    chk("m_dbv", db_in_valid, 1);
    tick();
    db_out_valid = 1'b0;
    chk("m_rsp2", rsp_valid, 4'b1000);
    chk("m_out4", outstanding, 4);

    // orphan with nothing in flight
    do_reset();
    db_out_valid = 1'b1;
    tick();
    db_out_valid = 1'b0;
    chk("o_orph", orphan, 1);
    chk("o_rsp", rsp_valid, 0);
    chk("o_out", outstanding, 0);
    tick();
    chk("o_orph0", orphan, 0);

    // reset with three in flight
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = 4'hF;
    chk("r_out3", outstanding, 3);
    eth_rst_n = 1'b0;
    #1;
    chk("r_out0", outstanding, 0);
    chk("r_ready", req_ready, 0);
    req_valid = '0;
    tick();
    eth_rst_n    = 1'b1;
    db_out_valid = 1'b1;
    tick();
    chk("r_orph1", orphan, 1);
    chk("r_rsp1", rsp_valid, 0);
    tick();
    db_out_valid = 1'b0;
    chk("r_orph2", orphan, 1);
    tick();
    chk("r_orph0", orphan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
